pow2k_pipe: RTL and testbench
=============================

// Module: pow2k_pipe
// PURPOSE
//  Parametrised successor to the fixed pow8 datapath: computes x^(2^LOG2_EXP) mod 2^OUT_W
//  via LOG2_EXP registered squaring stages, each with its own valid bit.
//  Valid/ready on both sides; bubble-collapsing backpressure gives full throughput (1 item/clk).
//  Sits between a valid/ready producer and consumer in the COM_IF/AXI-stream datapath.
// PARAMETERS
//  IN_W      32  input operand width (bits), unsigned
//  OUT_W     64  result width; all arithmetic is mod 2^OUT_W; must satisfy OUT_W >= IN_W
//  LOG2_EXP  3   number of squaring stages; exponent = 2^LOG2_EXP (3 -> x^8); range 1..6
// PORTS
//  clk       in   1      single clock, rising edge
//  reset     in   1      synchronous, active-high reset
//  s_valid   in   1      input item valid
//  s_ready   out  1      pipe can accept an input item this cycle
//  s_data    in   IN_W   operand x
//  m_valid   out  1      result valid
//  m_ready   in   1      consumer accepts result
//  m_data    out  OUT_W  x^(2^LOG2_EXP) mod 2^OUT_W
// BEHAVIOUR
//  - Stage 0 takes zero-extended s_data (OUT_W bits); stage i registers (stage i-1 value)^2,
//    truncated to the OUT_W LSBs; the truncation is exact mod 2^OUT_W. m_data/m_valid = last stage.
//  - Handshakes: s_hs = s_valid & s_ready; m_hs = m_valid & m_ready.
//  - Per-stage rdy[i] = ~vld[i] | rdy[i+1], with rdy[LOG2_EXP] = m_ready; s_ready = rdy[0].
//  - s_ready is combinational from m_ready and the stage valids. No path from s_valid to s_ready.
//  - Stage i loads when rdy[i]: vld[i] <= vld[i-1] (s_valid for i=0). Otherwise it holds data and valid.
//  - Latency: LOG2_EXP cycles from s_hs to m_valid when the pipe is empty and m_ready=1.
//  - Throughput: one item per clk when m_ready is held high. Full depth = LOG2_EXP items.
//  - Full pipe with m_ready=0: s_ready=0; m_data/m_valid hold stable until m_hs.
//  - Simultaneous m_hs and s_hs on a full pipe: both complete in the same cycle, nothing lost.
//  - Items leave in acceptance order. No drop, no duplication.
//  - Bubbles: an empty stage downstream of a stalled stage still loads, so gaps compress under stall.
//  - Data regs are not reset. Only the valid bits are reset.
//  - Reset: all vld <= 0, so m_valid=0 and s_ready=1 in the first cycle after reset deasserts.
//  - Reset mid-operation: in-flight items are discarded and produce no output.
//  - No FSM: control state is the LOG2_EXP valid bits.
// CONFIGURATION
//  POW2K_STAT_EN defined: adds ports
//    in_cnt  out 32 (+1 per s_hs)
//    out_cnt out 32 (+1 per m_hs)
//    occ     out 8  (number of set stage valids)
//  - Counters are reset to 0 by reset and wrap 0xFFFFFFFF -> 0.
//  - If s_hs and m_hs occur in the same cycle, each counter still increments.
//  POW2K_STAT_EN undefined: these ports and their logic are absent; datapath is identical.
// TESTING  (IN_W=32, OUT_W=64, LOG2_EXP=3 unless noted)
//  1. x=2, then x=3, m_ready=1 -> m_data=256 then 6561; first m_valid 3 clk after s_hs.
//  2. x=0xFFFFFFFF -> m_data=0xFFFFFFF8_00000001. x=256 -> m_data=0 (wrap mod 2^64).
//  3. x=0..99, s_valid and m_ready both $urandom%2 -> out[k]=k^8 mod 2^64, in order, 100 results.
//  4. s_valid=1 continuous, m_ready=0 for 10 clk -> exactly 3 accepted; then s_ready=0 and
//     m_data stable. m_ready=1 -> 1 result/clk, no loss.
//  5. Reset pulse with 2 items in flight -> m_valid=0 next clk, s_ready=1; no stale result later.
//  6. With POW2K_STAT_EN: after test 3, in_cnt=out_cnt=100 and occ=0. LOG2_EXP=1 with x=7
//     -> m_data=49, latency 1.

Source files
------------

// File: rtl/pow2k_pipe_if.sv
// Valid/ready stream bundle of width W; master drives valid/data, slave drives ready.
interface pow2k_pipe_if #(
  parameter int W = 32
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pow2k_pipe.sv
// pow2k_pipe: x^(2^LOG2_EXP) mod 2^OUT_W through LOG2_EXP registered squaring stages with
// bubble-collapsing valid/ready backpressure. Optional statistics ports under `POW2K_STAT_EN.
module pow2k_pipe #(
  parameter int IN_W     = 32,
  parameter int OUT_W    = 64,
  parameter int LOG2_EXP = 3
) (
  input  logic              clk,
  input  logic              reset,
  pow2k_pipe_if.slave       s_if,
  pow2k_pipe_if.master      m_if
`ifdef POW2K_STAT_EN
  ,
  output logic [31:0]       in_cnt,
  output logic [31:0]       out_cnt,
  output logic [7:0]        occ
`endif
);

  function automatic logic [OUT_W-1:0] sq(input logic [OUT_W-1:0] a);
    return a * a;
  endfunction

  logic [LOG2_EXP-1:0] r_vld;
  logic [OUT_W-1:0]    r_data [LOG2_EXP];
  logic [LOG2_EXP:0]   w_rdy;
  logic [LOG2_EXP-1:0] w_in_vld;
  logic [OUT_W-1:0]    w_in_sq [LOG2_EXP];
  logic                w_acc;

  // A stage may advance if it is empty or everything downstream of it can advance.
  always_comb begin
    w_rdy           = '0;
    w_acc           = m_if.ready;
    w_rdy[LOG2_EXP] = w_acc;
    for (int i = LOG2_EXP - 1; i >= 0; i--) begin
      w_acc    = w_acc | ~r_vld[i];
      w_rdy[i] = w_acc;
    end
  end

  // Next value offered to each stage: squared upstream data plus its valid.
  always_comb begin
    w_in_vld    = '0;
    w_in_vld[0] = s_if.valid;
    w_in_sq[0]  = sq(OUT_W'(s_if.data));
    for (int i = 1; i < LOG2_EXP; i++) begin
      w_in_vld[i] = r_vld[i-1];
      w_in_sq[i]  = sq(r_data[i-1]);
    end
  end

  // Stage valid bits: the only reset control state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld <= '0;
    end else begin
      for (int i = 0; i < LOG2_EXP; i++) begin
        if (w_rdy[i]) r_vld[i] <= w_in_vld[i];
      end
    end
  end

  // Data registers are left unreset; a stale word is never visible without its valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LOG2_EXP; i++) begin
      if (w_rdy[i]) r_data[i] <= w_in_sq[i];
    end
  end

  assign s_if.ready = w_rdy[0];
  assign m_if.valid = r_vld[LOG2_EXP-1];
  assign m_if.data  = r_data[LOG2_EXP-1];

`ifdef POW2K_STAT_EN
  logic       w_s_hs;
  logic       w_m_hs;
  logic [7:0] w_occ;

  assign w_s_hs = s_if.valid & w_rdy[0];
  assign w_m_hs = r_vld[LOG2_EXP-1] & m_if.ready;

  // Handshake counters, wrapping naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_cnt  <= 32'd0;
      out_cnt <= 32'd0;
    end else begin
      if (w_s_hs) in_cnt  <= in_cnt + 32'd1;
      if (w_m_hs) out_cnt <= out_cnt + 32'd1;
    end
  end

  // Occupancy is the population count of the stage valids.
  always_comb begin
    w_occ = 8'd0;
    for (int i = 0; i < LOG2_EXP; i++) begin
      w_occ = w_occ + 8'(r_vld[i]);
    end
  end

  assign occ = w_occ;
`endif

endmodule

// File: tb/tb_pow2k_pipe.sv
// Scoreboard bench for pow2k_pipe: the input monitor queues expected results on each accept,
// the output monitor pops and compares on each output handshake.
module tb_pow2k_pipe;
  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   nout;
  logic [63:0] cur_exp;
  logic [63:0] sb [$];

  pow2k_pipe_if #(.W(32)) s_bus ();
  pow2k_pipe_if #(.W(64)) m_bus ();
  pow2k_pipe_if #(.W(32)) s1_bus ();
  pow2k_pipe_if #(.W(64)) m1_bus ();

`ifdef POW2K_STAT_EN
  logic [31:0] in_cnt, out_cnt, in1_cnt, out1_cnt;
  logic [7:0]  occ, occ1;
`endif

  pow2k_pipe #(.IN_W(32), .OUT_W(64), .LOG2_EXP(3)) u_dut (
    .clk(clk), .reset(reset), .s_if(s_bus), .m_if(m_bus)
`ifdef POW2K_STAT_EN
    , .in_cnt(in_cnt), .out_cnt(out_cnt), .occ(occ)
`endif
  );

  pow2k_pipe #(.IN_W(32), .OUT_W(64), .LOG2_EXP(1)) u_dut1 (
    .clk(clk), .reset(reset), .s_if(s1_bus), .m_if(m1_bus)
`ifdef POW2K_STAT_EN
    , .in_cnt(in1_cnt), .out_cnt(out1_cnt), .occ(occ1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] pow8(input logic [63:0] x);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < 8; i++) r = r * x;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%h required=0x%h", name, act, exp);
    end
  endtask

  task automatic load(input logic [31:0] x);
    s_bus.data = x;
    cur_exp    = pow8(64'(x));
  endtask

  task automatic send(input logic [31:0] x, input logic [63:0] e);
    int w;
    @(posedge clk); #1;
    s_bus.valid = 1'b1;
    s_bus.data  = x;
    cur_exp     = e;
    w = 0;
    @(negedge clk);
    while (!s_bus.ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!s_bus.ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=stalled required=accept x=0x%h", x);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    s_bus.valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((sb.size() != 0 || m_bus.valid) && w < 500) begin
      @(negedge clk);
      w++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  // Input monitor: every accepted operand queues its expected result.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && s_bus.valid && s_bus.ready) sb.push_back(cur_exp);
    end
  end

  // Output monitor: every output handshake is checked against the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && m_bus.valid && m_bus.ready) begin
        nout++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=0x%h required=none", m_bus.data);
        end else begin
          chk("result", m_bus.data, sb.pop_front());
        end
      end
    end
  end

  initial begin
    int n, k, acc, nxt, n0;
    logic took;
    logic [63:0] snap;
    checks = 0; errors = 0; nout = 0; cur_exp = 64'd0;
    reset = 1'b1;
    s_bus.valid = 1'b0; s_bus.data = 32'd0; m_bus.ready = 1'b0;
    s1_bus.valid = 1'b0; s1_bus.data = 32'd0; m1_bus.ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_m_valid", 64'(m_bus.valid), 64'd0);
    chk("rst_s_ready", 64'(s_bus.ready), 64'd1);

    // Test 1: small operands and latency.
    m_bus.ready = 1'b1;
    send(32'd2, 64'd256);
    idle();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_bus.valid && n < 20);
    chk("latency", 64'(n), 64'd3);
    send(32'd3, 64'd6561);
    idle();
    drain();

    // Test 2: wrap-around corners, back to back.
    send(32'hFFFF_FFFF, 64'hFFFF_FFF8_0000_0001);
    send(32'd256, 64'd0);
    send(32'h80, 64'h0100_0000_0000_0000);
    send(32'd17, 64'd6975757441);
    idle();
    drain();

    // Test 3: 100 items, random valid and ready, after a fresh reset.
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
`ifdef POW2K_STAT_EN
    @(negedge clk);
    chk("stat_in_rst", 64'(in_cnt), 64'd0);
`endif
    n0 = nout; k = 0; took = 1'b0;
    for (int cyc = 0; cyc < 5000 && (k < 100 || s_bus.valid); cyc++) begin
      @(posedge clk); #1;
      if (took) s_bus.valid = 1'b0;
      m_bus.ready = 1'($urandom % 2);
      if (!s_bus.valid && k < 100 && ($urandom % 2) == 1) begin
        s_bus.valid = 1'b1;
        load(32'(k));
        k++;
      end
      @(negedge clk);
      took = s_bus.valid & s_bus.ready;
    end
    @(posedge clk); #1;
    s_bus.valid = 1'b0;
    m_bus.ready = 1'b1;
    drain();
    chk("rand_count", 64'(nout - n0), 64'd100);
`ifdef POW2K_STAT_EN
    chk("stat_in_cnt", 64'(in_cnt), 64'd100);
    chk("stat_out_cnt", 64'(out_cnt), 64'd100);
    chk("stat_occ", 64'(occ), 64'd0);
`endif

    // Test 4: stall with continuous input, then release.
    @(posedge clk); #1;
    m_bus.ready = 1'b0;
    s_bus.valid = 1'b1;
    nxt = 10;
    load(32'(nxt));
    acc = 0;
    repeat (10) begin
      @(negedge clk);
      took = s_bus.ready;
      if (took) acc++;
      @(posedge clk); #1;
      if (took) begin
        nxt++;
        load(32'(nxt));
      end
    end
    chk("stall_accepted", 64'(acc), 64'd3);
    @(negedge clk);
    chk("stall_s_ready", 64'(s_bus.ready), 64'd0);
    chk("stall_m_valid", 64'(m_bus.valid), 64'd1);
    chk("stall_m_data", m_bus.data, 64'd100000000);
    snap = m_bus.data;
    repeat (3) @(negedge clk);
    chk("stall_hold", m_bus.data, snap);
    @(posedge clk); #1;
    m_bus.ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("thru_s_ready", 64'(s_bus.ready), 64'd1);
      @(posedge clk); #1;
      if (i < 2) begin
        nxt++;
        load(32'(nxt));
      end else begin
        s_bus.valid = 1'b0;
      end
    end
    drain();

    // Test 5: reset with two items in flight.
    send(32'd5, 64'd390625);
    send(32'd6, 64'd1679616);
    idle();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    n0 = nout;
    @(negedge clk);
    chk("midrst_m_valid", 64'(m_bus.valid), 64'd0);
    chk("midrst_s_ready", 64'(s_bus.ready), 64'd1);
`ifdef POW2K_STAT_EN
    chk("midrst_occ", 64'(occ), 64'd0);
`endif
    repeat (10) @(negedge clk);
    chk("midrst_no_output", 64'(nout - n0), 64'd0);

    // Test 6: single-stage instance, x=7.
    @(posedge clk); #1;
    s1_bus.valid = 1'b1;
    s1_bus.data  = 32'd7;
    @(negedge clk);
    chk("l1_s_ready", 64'(s1_bus.ready), 64'd1);
    @(posedge clk); #1;
    s1_bus.valid = 1'b0;
    @(negedge clk);
    chk("l1_m_valid", 64'(m1_bus.valid), 64'd1);
    chk("l1_m_data", m1_bus.data, 64'd49);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
